// File: rtl/sram_bus_responder_pkg.sv
// ---------------------------------------------------------------------------
// sram_bus_responder_pkg : shared FSM encoding and fill byte for the SRAM bus target
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sram_bus_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_WRITE  = 2'd2,
    S_COMMIT = 2'd3
  } state_e;

  localparam logic [7:0] FILL_DEFAULT = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/sram_bus_responder_mem.sv
// ---------------------------------------------------------------------------
// sram_emu_mem : 1W/1R synchronous byte RAM standing in for the external SRAM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_emu_mem #(
  parameter int    AW        = 11,
  parameter int    DEPTH     = 2048,
  parameter string INIT_FILE = ""
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [0:DEPTH-1];
  logic [7:0] rdata_q;

  // Read-first: a same-edge write is not visible; the top covers that with its bypass.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/sram_bus_responder.sv
// ---------------------------------------------------------------------------
// sram_bus_responder : async-SRAM bus target emulating the external SRAM in BRAM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_bus_responder
  import sram_bus_responder_pkg::*;
#(
  parameter int          ADDR_W    = 11,
  parameter int          MEM_WORDS = 2048,
  parameter logic [7:0]  FILL      = FILL_DEFAULT,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cen_n,
  input  logic              oen_n,
  input  logic              wen_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              dout_oe,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              oor_err,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
);

  localparam int              MEM_AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_WORDS);

  function automatic logic is_oor(input logic [ADDR_W-1:0] a);
    return {1'b0, a} >= MEM_LIMIT;
  endfunction

  logic              cen_q, oen_q, wen_q;
  logic [ADDR_W-1:0] addr_q, pend_addr_q;
  logic [7:0]        din_q, pend_data_q, byp_data_q;
  state_e            state_q, state_d;
  logic              dout_oe_q, sel_fill_q, sel_byp_q, oor_rd_q, oor_err_q;
  logic [15:0]       wr_count_q, rd_count_q;

  logic              wr_w, rd_w, commit_w, pend_live_w, rd_oor_w;
  logic              mem_we_w;
  logic [MEM_AW-1:0] mem_waddr_w;
  logic [7:0]        mem_wdata_w, mem_rdata_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cen_q  <= 1'b1;
      oen_q  <= 1'b1;
      wen_q  <= 1'b1;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      cen_q  <= cen_n;
      oen_q  <= oen_n;
      wen_q  <= wen_n;
      addr_q <= addr;
      din_q  <= din;
    end
  end

  assign wr_w        = !cen_q && !wen_q;
  assign rd_w        = !cen_q && !oen_q && wen_q;
  assign commit_w    = (state_q == S_COMMIT);
  assign pend_live_w = (state_q == S_WRITE) || commit_w;
  assign rd_oor_w    = rd_w && is_oor(addr_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (wr_w) state_d = S_WRITE; else if (rd_w) state_d = S_READ;
      S_READ:   if (wr_w) state_d = S_WRITE; else if (!rd_w) state_d = S_IDLE;
      S_WRITE:  if (!wr_w) state_d = S_COMMIT;
      S_COMMIT: if (wr_w) state_d = S_WRITE; else if (rd_w) state_d = S_READ;
                else state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Backdoor only fills otherwise-dead cycles, so it never collides with a commit.
  assign ld_ready    = !reset && (state_q == S_IDLE) && !rd_w && !wr_w;
  assign mem_we_w    = (commit_w && !is_oor(pend_addr_q)) ||
                       (ld_valid && ld_ready && !is_oor(ld_addr));
  assign mem_waddr_w = commit_w ? pend_addr_q[MEM_AW-1:0] : ld_addr[MEM_AW-1:0];
  assign mem_wdata_w = commit_w ? pend_data_q : ld_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      byp_data_q  <= '0;
      dout_oe_q   <= 1'b0;
      sel_fill_q  <= 1'b0;
      sel_byp_q   <= 1'b0;
      oor_rd_q    <= 1'b0;
      oor_err_q   <= 1'b0;
      wr_count_q  <= '0;
      rd_count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (wr_w) begin
        pend_addr_q <= addr_q;
        pend_data_q <= din_q;
      end
      dout_oe_q  <= rd_w;
      sel_fill_q <= is_oor(addr_q);
      sel_byp_q  <= pend_live_w && (addr_q == pend_addr_q);
      byp_data_q <= pend_data_q;
      oor_rd_q   <= rd_oor_w;
      oor_err_q  <= (rd_oor_w && !oor_rd_q) || (commit_w && is_oor(pend_addr_q));
      if (commit_w) wr_count_q <= wr_count_q + 16'd1;
      if ((state_d == S_READ) && (state_q != S_READ)) rd_count_q <= rd_count_q + 16'd1;
    end
  end

  sram_emu_mem #(
    .AW        (MEM_AW),
    .DEPTH     (MEM_WORDS),
    .INIT_FILE (INIT_FILE)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we_w),
    .waddr_i (mem_waddr_w),
    .wdata_i (mem_wdata_w),
    .raddr_i (addr_q[MEM_AW-1:0]),
    .rdata_o (mem_rdata_w)
  );

  // Gating with wen_q drops the drivers the very cycle a write is seen on the pins.
  assign dout_oe  = dout_oe_q && wen_q;
  assign dout     = !dout_oe_q ? 8'h00 :
                    sel_fill_q ? FILL  :
                    sel_byp_q  ? byp_data_q : mem_rdata_w;
  assign oor_err  = oor_err_q;
  assign wr_count = wr_count_q;
  assign rd_count = rd_count_q;

  a_no_drive_on_write: assert property (@(posedge clk) disable iff (reset) !(dout_oe && !wen_q));

endmodule

`default_nettype wire

// File: tb/tb_sram_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_sram_bus_responder : scoreboard bench for the SRAM bus target, 1 KiB config
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sram_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        cen_n, oen_n, wen_n;
  logic [10:0] addr, ld_addr;
  logic [7:0]  din, ld_data, dout;
  logic        dout_oe, ld_valid, ld_ready, oor_err;
  logic [15:0] wr_count, rd_count;

  int          n_checks = 0;
  int          n_errors = 0;
  int          oor_pulses = 0;
  logic [7:0]  model [0:1023];
  logic [7:0]  exp_q [$];

  sram_bus_responder #(
    .ADDR_W    (11),
    .MEM_WORDS (1024),
    .FILL      (8'hFF),
    .INIT_FILE ("")
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cen_n    (cen_n),
    .oen_n    (oen_n),
    .wen_n    (wen_n),
    .addr     (addr),
    .din      (din),
    .dout     (dout),
    .dout_oe  (dout_oe),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .oor_err  (oor_err),
    .wr_count (wr_count),
    .rd_count (rd_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!reset && oor_err) oor_pulses++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    cen_n = 1'b1; oen_n = 1'b1; wen_n = 1'b1;
  endtask

  task automatic backdoor(input logic [10:0] a, input logic [7:0] d);
    int k = 0;
    ld_addr = a; ld_data = d; ld_valid = 1'b1;
    while (!ld_ready && k < 20) begin cyc(1); k++; end
    check("ld_ready", ld_ready, 1);
    cyc(1);
    ld_valid = 1'b0;
    if (a < 11'd1024) model[a[9:0]] = d;
  endtask

  task automatic bus_write(input logic [10:0] a, input logic [7:0] d, input int n);
    cen_n = 1'b0; oen_n = 1'b1; wen_n = 1'b0; addr = a; din = d;
    cyc(n);
    wen_n = 1'b1;
  endtask

  task automatic read_start(input logic [10:0] a);
    cen_n = 1'b0; oen_n = 1'b0; wen_n = 1'b1; addr = a;
    exp_q.push_back((a < 11'd1024) ? model[a[9:0]] : 8'hFF);
  endtask

  task automatic read_collect(input string tag);
    int   k = 0;
    logic [7:0] e;
    while (!dout_oe && k < 6) begin cyc(1); k++; end
    e = exp_q.pop_front();
    check({tag, "_oe"}, dout_oe, 1);
    check(tag, dout, e);
  endtask

  initial begin
    reset = 1'b1; bus_idle(); addr = '0; din = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    cyc(2);
    check("rst_dout", dout, 8'h00);
    check("rst_oe", dout_oe, 0);
    check("rst_ldr", ld_ready, 0);
    check("rst_oor", oor_err, 0);
    check("rst_wrc", wr_count, 0);
    check("rst_rdc", rd_count, 0);
    reset = 1'b0;
    cyc(1);

    // 1: backdoor preload then read with exact two-edge latency
    backdoor(11'h010, 8'hA5);
    backdoor(11'h100, 8'h11);
    backdoor(11'h080, 8'h42);
    read_start(11'h010);
    cyc(1);
    check("t1_lat1_oe", dout_oe, 0);
    cyc(1);
    read_collect("t1_rd");
    check("t1_rdc", rd_count, 1);
    bus_idle();
    cyc(1);
    check("t1_oe_hold", dout_oe, 1);
    cyc(1);
    check("t1_oe_drop", dout_oe, 0);

    // 2: three-cycle write, one commit, readback
    bus_write(11'h123, 8'h5C, 3);
    bus_idle();
    model[10'h123] = 8'h5C;
    cyc(4);
    check("t2_wrc", wr_count, 1);
    read_start(11'h123);
    read_collect("t2_rd");
    bus_idle();
    cyc(3);

    // 3: read straight after the write strobe rises goes through the bypass
    bus_write(11'h040, 8'h77, 2);
    model[10'h040] = 8'h77;
    read_start(11'h040);
    read_collect("t3_bypass");
    cyc(2);
    check("t3_hold", dout, 8'h77);
    bus_idle();
    cyc(3);
    check("t3_wrc", wr_count, 2);
    check("t3_rdc", rd_count, 3);

    // 4: out-of-range read and write
    read_start(11'h500);
    read_collect("t4_fill");
    cyc(2);
    bus_idle();
    cyc(3);
    check("t4_oor_rd", oor_pulses, 1);
    bus_write(11'h500, 8'h33, 2);
    bus_idle();
    cyc(5);
    check("t4_wrc", wr_count, 3);
    check("t4_oor_wr", oor_pulses, 2);
    read_start(11'h100);
    read_collect("t4_alias");
    bus_idle();
    cyc(3);

    // 5: OEn and WEn low together, backdoor held off by bus traffic
    cen_n = 1'b0; oen_n = 1'b0; wen_n = 1'b0; addr = 11'h200; din = 8'h9A;
    cyc(1);
    ld_valid = 1'b1; ld_addr = 11'h300; ld_data = 8'h66;
    for (int i = 0; i < 3; i++) begin
      check("t5_oe", dout_oe, 0);
      check("t5_ldr", ld_ready, 0);
      cyc(1);
    end
    bus_idle();
    model[10'h200] = 8'h9A;
    backdoor(11'h300, 8'h66);
    check("t5_wrc", wr_count, 4);
    read_start(11'h200);
    read_collect("t5_rd_bus");
    bus_idle();
    cyc(2);
    read_start(11'h300);
    read_collect("t5_rd_ld");
    bus_idle();
    cyc(3);
    check("t5_rdc", rd_count, 7);

    // 6: reset during a read, then during a write
    cen_n = 1'b0; oen_n = 1'b0; wen_n = 1'b1; addr = 11'h010;
    cyc(2);
    check("t6_rd_oe", dout_oe, 1);
    reset = 1'b1;
    #1;
    check("t6_rst_oe", dout_oe, 0);
    bus_idle();
    cyc(1);
    reset = 1'b0;
    cyc(1);
    cen_n = 1'b0; oen_n = 1'b1; wen_n = 1'b0; addr = 11'h080; din = 8'hEE;
    cyc(3);
    reset = 1'b1;
    #1;
    check("t6_rst_wrc", wr_count, 0);
    check("t6_rst_rdc", rd_count, 0);
    check("t6_rst_oe2", dout_oe, 0);
    bus_idle();
    cyc(2);
    reset = 1'b0;
    cyc(4);
    check("t6_no_commit", wr_count, 0);
    read_start(11'h080);
    read_collect("t6_kept_080");
    bus_idle();
    cyc(2);
    read_start(11'h010);
    read_collect("t6_kept_010");
    bus_idle();
    cyc(3);
    check("t6_rdc", rd_count, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
